// File: rtl/fmult_arb_pkg.sv
// rtl/fmult_arb_pkg.sv - shared types and constants for the multiplier arbiter
// Purpose: FSM state encoding, response flag bit positions, timeout result value,
//          fp16 zero-extension width and small helpers used by fmult_arb.
// Ports:   none (package).
package fmult_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Bit positions inside the 3-bit {timeout, error, overflow} flag field.
   localparam int FLAG_OVF = 0;
   localparam int FLAG_ERR = 1;
   localparam int FLAG_TMO = 2;

   localparam logic [31:0] NAN_32    = 32'h7fffffff;
   localparam int          FP16_ZEXT = 16;

   function automatic logic [31:0] zext16(input logic [15:0] v);
      return {{FP16_ZEXT{1'b0}}, v};
   endfunction

   function automatic logic [2:0] make_flags(input logic tmo, input logic err,
                                             input logic ovf);
      logic [2:0] f;
      f           = '0;
      f[FLAG_TMO] = tmo;
      f[FLAG_ERR] = err;
      f[FLAG_OVF] = ovf;
      return f;
   endfunction

endpackage

// File: rtl/fmult_arb_rr_arb2.sv
// rtl/fmult_arb_rr_arb2.sv - two-way round-robin arbiter with last-grant register
// Purpose: picks one of two requesters; on a tie the one not granted last wins.
// Ports:   clk, rst_n      clock, async active-low reset
//          req[1:0]        pending requests
//          update          load update_id into the last-grant register
//          update_id       index of the requester just served
//          grant[1:0]      one-hot grant (combinational, zero when no request)
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       update_id,
   output logic [1:0] grant
);

   logic last;

   // Reset value 1 makes requester 0 the winner of the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= 1'b1;
      end else if (update) begin
         last <= update_id;
      end
   end

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/fmult_arb.sv
// rtl/fmult_arb.sv - arbitrates two requesters onto one external fp16/fp32 multiplier
// Purpose: grants one job at a time (round-robin), issues it to the multiplier,
//          waits for the result with a minimum wait and a timeout, and holds the
//          response for the granted requester until it is consumed.
// Ports:   clk, rst_n                       clock, async active-low reset
//          req{0,1}_valid/ready/type/a/b    job request handshake and operands
//          rsp{0,1}_valid/ready/data/flags  result handshake, data, {tmo,err,ovf}
//          mul_valid/data_type/in*          job issue to the multiplier
//          mul_ready/out*/overflow/error    multiplier status and result
module fmult_arb
   import fmult_arb_pkg::*;
#(
   parameter int MIN_WAIT = 3,
   parameter int TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_type,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_type,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_data,
   output logic [2:0]  rsp0_flags,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_data,
   output logic [2:0]  rsp1_flags,
   output logic        mul_valid,
   output logic        mul_data_type,
   output logic [31:0] mul_in1_32,
   output logic [31:0] mul_in2_32,
   output logic [15:0] mul_in1_16,
   output logic [15:0] mul_in2_16,
   input  logic        mul_ready,
   input  logic [31:0] mul_out_32,
   input  logic [15:0] mul_out_16,
   input  logic        mul_overflow,
   input  logic        mul_error
);

   localparam logic [7:0] MIN_CNT = 8'(MIN_WAIT);
   localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

   state_t      state;
   logic        armed;
   logic [7:0]  cnt;
   logic        gnt_id;
   logic        op_type;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] res_data;
   logic [2:0]  res_flags;
   logic [1:0]  rsp_vld;
   logic        mul_vld;
   logic [1:0]  grant;
   logic        start;
   logic        handshake;

   // armed stays low for the first edge after reset release, so the earliest
   // grant lands on the second rising edge.
   assign start      = (state == ST_IDLE) && armed && mul_ready
                       && (req0_valid || req1_valid);
   assign req0_ready = start && grant[0];
   assign req1_ready = start && grant[1];
   assign handshake  = (rsp_vld[0] && rsp0_ready) || (rsp_vld[1] && rsp1_ready);

   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       ({req1_valid, req0_valid}),
      .update    (handshake),
      .update_id (gnt_id),
      .grant     (grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         armed     <= 1'b0;
         cnt       <= '0;
         gnt_id    <= 1'b0;
         op_type   <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         res_data  <= '0;
         res_flags <= '0;
         rsp_vld   <= '0;
         mul_vld   <= 1'b0;
      end else begin
         armed   <= 1'b1;
         mul_vld <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  gnt_id  <= grant[1];
                  op_type <= grant[1] ? req1_type : req0_type;
                  op_a    <= grant[1] ? req1_a : req0_a;
                  op_b    <= grant[1] ? req1_b : req0_b;
                  mul_vld <= 1'b1;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt   <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if ((cnt >= MIN_CNT) && mul_ready) begin
                  res_data        <= op_type ? mul_out_32 : zext16(mul_out_16);
                  res_flags       <= make_flags(1'b0, mul_error, mul_overflow);
                  rsp_vld[gnt_id] <= 1'b1;
                  state           <= ST_RESP;
               end else if (cnt == TMO_CNT) begin
                  res_data        <= NAN_32;
                  res_flags       <= make_flags(1'b1, 1'b0, 1'b0);
                  rsp_vld[gnt_id] <= 1'b1;
                  state           <= ST_RESP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_RESP: begin
               if (handshake) begin
                  rsp_vld <= '0;
                  cnt     <= '0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign rsp0_valid    = rsp_vld[0];
   assign rsp1_valid    = rsp_vld[1];
   assign rsp0_data     = res_data;
   assign rsp1_data     = res_data;
   assign rsp0_flags    = res_flags;
   assign rsp1_flags    = res_flags;
   assign mul_valid     = mul_vld;
   assign mul_data_type = op_type;
   assign mul_in1_32    = op_a;
   assign mul_in2_32    = op_b;
   assign mul_in1_16    = op_a[15:0];
   assign mul_in2_16    = op_b[15:0];

endmodule
